// File: rtl/systolic_output_collector.sv
// systolic_output_collector: per-column FIFOs re-align skewed bottom-row PE sums into whole rows
// and hand them off on a registered valid/ready port, flagging done after SIZE rows.
module systolic_output_collector #(
  parameter int ACC_WIDTH = 9,
  parameter int SIZE = 2,
  localparam int IDXW = SIZE > 1 ? $clog2(SIZE) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [SIZE-1:0]           col_valid,
  input  logic [SIZE*ACC_WIDTH-1:0] col_sum,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SIZE*ACC_WIDTH-1:0] res_row,
  output logic [IDXW-1:0]           res_row_idx,
  output logic                      res_last,
  output logic                      done,
  output logic                      overflow
);
  localparam int CW = $clog2(SIZE + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;
  state_e state_q, state_d;
  logic [ACC_WIDTH-1:0] mem_q [SIZE][SIZE];
  logic [ACC_WIDTH-1:0] mem_d [SIZE][SIZE];
  logic [CW-1:0] cnt_q [SIZE];
  logic [CW-1:0] cnt_d [SIZE];
  logic [CW-1:0] loaded_q, loaded_d, sent_q, sent_d, wi;
  logic [SIZE*ACC_WIDTH-1:0] row_q, row_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic valid_q, valid_d, last_q, last_d, ovf_q, ovf_d;
  logic [SIZE-1:0] nonempty, full;
  logic collect, load, hs, push;
  always_comb begin
    collect = state_q == COLLECT && !start;
    for (int j = 0; j < SIZE; j++) begin
      nonempty[j] = cnt_q[j] != '0;
      full[j] = cnt_q[j] == CW'(SIZE);
    end
    hs = valid_q && res_ready;
    load = collect && &nonempty && loaded_q < CW'(SIZE) && (!valid_q || res_ready);
    mem_d = mem_q;
    cnt_d = cnt_q;
    state_d = state_q;
    loaded_d = loaded_q;
    sent_d = sent_q;
    row_d = row_q;
    idx_d = idx_q;
    valid_d = valid_q;
    last_d = last_q;
    ovf_d = ovf_q;
    wi = '0;
    push = 1'b0;
    // FIFOs shift toward entry 0 on pop, so a simultaneous push lands one slot lower
    for (int j = 0; j < SIZE; j++) begin
      if (load) begin
        row_d[j*ACC_WIDTH +: ACC_WIDTH] = mem_q[j][0];
        for (int k = 0; k < SIZE - 1; k++) mem_d[j][k] = mem_q[j][k+1];
      end
      wi = cnt_q[j] - CW'(load);
      push = collect && col_valid[j] && (!full[j] || load);
      if (push) mem_d[j][wi[IDXW-1:0]] = col_sum[j*ACC_WIDTH +: ACC_WIDTH];
      if (collect && col_valid[j] && !push) ovf_d = 1'b1;
      cnt_d[j] = cnt_q[j] + CW'(push) - CW'(load);
    end
    if (load) begin
      valid_d = 1'b1;
      idx_d = loaded_q[IDXW-1:0];
      last_d = loaded_q == CW'(SIZE - 1);
      loaded_d = loaded_q + 1'b1;
    end else if (hs) begin
      valid_d = 1'b0;
    end
    if (hs) begin
      sent_d = sent_q + 1'b1;
      if (last_q) state_d = DONE;
    end
    if (start) begin
      for (int j = 0; j < SIZE; j++) cnt_d[j] = '0;
      state_d = COLLECT;
      loaded_d = '0;
      sent_d = '0;
      row_d = '0;
      idx_d = '0;
      valid_d = 1'b0;
      last_d = 1'b0;
      ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '{default: '0};
      loaded_q <= '0;
      sent_q <= '0;
      row_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      loaded_q <= loaded_d;
      sent_q <= sent_d;
      row_q <= row_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign res_valid = valid_q;
  assign res_row = row_q;
  assign res_row_idx = idx_q;
  assign res_last = last_q;
  assign done = state_q == DONE;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_systolic_output_collector.sv
// tb_systolic_output_collector: directed test-plan scenarios plus randomized traffic,
// all checked against a queue-based reference model of the collector.
module tb_systolic_output_collector;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_DONE = 2;
  logic clk = 0, rstn = 0, start = 0, res_ready = 0;
  logic [1:0] col_valid = 0;
  logic [17:0] col_sum = 0;
  logic res_valid, res_last, done, overflow;
  logic [17:0] res_row;
  logic [0:0] res_row_idx;
  int checks = 0, fails = 0;
  logic [8:0] mq [2][$];
  logic m_valid, m_last, m_ovf;
  logic [17:0] m_row;
  logic [0:0] m_idx;
  int m_loaded, m_sent, m_mode;
  wire [22:0] dvec = {res_valid, res_row, res_row_idx, res_last, done, overflow};

  systolic_output_collector dut (
    .clk(clk), .rstn(rstn), .start(start), .col_valid(col_valid), .col_sum(col_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
    .res_row_idx(res_row_idx), .res_last(res_last), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] mvec();
    return {m_valid, m_row, m_idx, m_last, m_mode == M_DONE, m_ovf};
  endfunction

  task automatic bad(input string nm, input logic [63:0] got, input logic [63:0] exp);
    fails++;
    $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic mreset();
    mq[0].delete();
    mq[1].delete();
    m_valid = 0; m_row = 0; m_idx = 0; m_last = 0; m_ovf = 0;
    m_loaded = 0; m_sent = 0; m_mode = M_IDLE;
  endtask

  // Reference: rows are popped from per-column queues, pushes into a full queue
  // survive only when that same cycle pops a row.
  task automatic mstep(input logic s, input logic [1:0] v, input logic [17:0] cs, input logic r);
    logic hs, ld, was_last;
    logic [1:0] ok;
    if (s) begin
      mreset();
      m_mode = M_COLLECT;
      return;
    end
    hs = m_valid && r;
    was_last = m_last;
    ld = m_mode == M_COLLECT && mq[0].size() > 0 && mq[1].size() > 0 && m_loaded < 2 && (!m_valid || r);
    for (int j = 0; j < 2; j++) ok[j] = mq[j].size() < 2 || ld;
    if (ld) begin
      m_row[8:0] = mq[0].pop_front();
      m_row[17:9] = mq[1].pop_front();
      m_idx = 1'(m_loaded);
      m_last = m_loaded == 1;
      m_loaded++;
      m_valid = 1;
    end else if (hs) m_valid = 0;
    if (m_mode == M_COLLECT)
      for (int j = 0; j < 2; j++)
        if (v[j]) begin
          if (ok[j]) mq[j].push_back(cs[j*9 +: 9]);
          else m_ovf = 1;
        end
    if (hs) begin
      m_sent++;
      if (was_last) m_mode = M_DONE;
    end
  endtask

  task automatic tick(input logic s, input logic [1:0] v, input logic [8:0] c0, input logic [8:0] c1, input logic r);
    start = s; col_valid = v; col_sum = {c1, c0}; res_ready = r;
    mstep(s, v, {c1, c0}, r);
    @(posedge clk);
    #1;
    start = 0; col_valid = 0;
  endtask

  task automatic test_reset();
    mreset();
    #2;
    checks++; if (dvec !== 23'd0) bad("reset_outputs", dvec, 0);
    @(negedge clk); rstn = 1;
    tick(0, 2'b11, 1, 2, 1);
    checks++; if (dvec !== mvec()) bad("reset_idle_ignores", dvec, mvec());
  endtask

  task automatic test_aligned();
    tick(1, 0, 0, 0, 1);
    tick(0, 2'b11, 5, 7, 1);
    checks++; if (res_valid !== 1'b0) bad("aligned_no_early_valid", res_valid, 0);
    tick(0, 2'b11, 11, 13, 1);
    checks++; if ({res_valid, res_row, res_row_idx, res_last} !== {1'b1, 9'd7, 9'd5, 1'b0, 1'b0}) bad("aligned_row0", {res_valid, res_row, res_row_idx, res_last}, {1'b1, 9'd7, 9'd5, 2'b00});
    checks++; if (dvec !== mvec()) bad("aligned_model0", dvec, mvec());
    tick(0, 0, 0, 0, 1);
    checks++; if ({res_valid, res_row, res_row_idx, res_last} !== {1'b1, 9'd13, 9'd11, 1'b1, 1'b1}) bad("aligned_row1", {res_valid, res_row, res_row_idx, res_last}, {1'b1, 9'd13, 9'd11, 2'b11});
    checks++; if (done !== 1'b0) bad("aligned_done_early", done, 0);
    tick(0, 0, 0, 0, 1);
    checks++; if ({done, res_valid} !== 2'b10) bad("aligned_done", {done, res_valid}, 2'b10);
    tick(0, 2'b11, 3, 3, 1);
    checks++; if (dvec !== mvec()) bad("done_ignores_input", dvec, mvec());
  endtask

  task automatic test_skewed();
    tick(1, 0, 0, 0, 1);
    tick(0, 2'b01, 5, 0, 1);
    tick(0, 2'b10, 0, 7, 1);
    checks++; if (res_valid !== 1'b0) bad("skew_t1_valid", res_valid, 0);
    tick(0, 0, 0, 0, 1);
    checks++; if ({res_valid, res_row} !== {1'b1, 9'd7, 9'd5}) bad("skew_t2_row", {res_valid, res_row}, {1'b1, 9'd7, 9'd5});
    checks++; if (dvec !== mvec()) bad("skew_model", dvec, mvec());
  endtask

  task automatic test_backpressure();
    tick(1, 0, 0, 0, 0);
    tick(0, 2'b11, 5, 7, 0);
    tick(0, 2'b11, 11, 13, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 0);
      checks++; if ({res_valid, res_row, res_row_idx, res_last} !== {1'b1, 9'd7, 9'd5, 2'b00}) bad("bp_hold", {res_valid, res_row, res_row_idx, res_last}, {1'b1, 9'd7, 9'd5, 2'b00});
    end
    tick(0, 0, 0, 0, 1);
    checks++; if ({res_valid, res_row, res_row_idx, res_last} !== {1'b1, 9'd13, 9'd11, 2'b11}) bad("bp_release_row1", {res_valid, res_row, res_row_idx, res_last}, {1'b1, 9'd13, 9'd11, 2'b11});
    checks++; if (dvec !== mvec()) bad("bp_model", dvec, mvec());
  endtask

  task automatic test_overflow();
    tick(1, 0, 0, 0, 1);
    tick(0, 2'b01, 1, 0, 1);
    tick(0, 2'b01, 2, 0, 1);
    checks++; if (overflow !== 1'b0) bad("ovf_not_yet", overflow, 0);
    tick(0, 2'b01, 3, 0, 1);
    checks++; if (overflow !== 1'b1) bad("ovf_set", overflow, 1);
    tick(0, 2'b10, 0, 9, 1);
    tick(0, 2'b10, 0, 10, 1);
    checks++; if ({res_valid, res_row, res_row_idx} !== {1'b1, 9'd9, 9'd1, 1'b0}) bad("ovf_row0", {res_valid, res_row, res_row_idx}, {1'b1, 9'd9, 9'd1, 1'b0});
    tick(0, 0, 0, 0, 1);
    checks++; if ({res_valid, res_row, res_row_idx, overflow} !== {1'b1, 9'd10, 9'd2, 1'b1, 1'b1}) bad("ovf_row1", {res_valid, res_row, res_row_idx, overflow}, {1'b1, 9'd10, 9'd2, 2'b11});
    tick(0, 0, 0, 0, 1);
    checks++; if (dvec !== mvec()) bad("ovf_model", dvec, mvec());
  endtask

  task automatic test_midframe_start();
    tick(1, 0, 0, 0, 1);
    tick(0, 2'b11, 1, 2, 1);
    tick(0, 2'b01, 4, 0, 1);
    tick(0, 0, 0, 0, 1);
    checks++; if (res_valid !== 1'b0) bad("mid_row0_sent", res_valid, 0);
    tick(1, 2'b11, 20, 21, 1);
    checks++; if ({res_valid, overflow, done} !== 3'b000) bad("mid_start_clear", {res_valid, overflow, done}, 0);
    tick(0, 2'b11, 6, 8, 1);
    tick(0, 0, 0, 0, 1);
    checks++; if ({res_valid, res_row, res_row_idx} !== {1'b1, 9'd8, 9'd6, 1'b0}) bad("mid_flushed_row", {res_valid, res_row, res_row_idx}, {1'b1, 9'd8, 9'd6, 1'b0});
    checks++; if (dvec !== mvec()) bad("mid_model", dvec, mvec());
  endtask

  task automatic test_rstn_pulse();
    tick(1, 0, 0, 0, 0);
    tick(0, 2'b11, 1, 2, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (res_valid !== 1'b1) bad("rst_pre_valid", res_valid, 1);
    #1 rstn = 0;
    mreset();
    #1;
    checks++; if (dvec !== 23'd0) bad("rst_async_clear", dvec, 0);
    #1 rstn = 1;
    @(posedge clk); #1;
    tick(0, 2'b11, 3, 4, 1);
    tick(0, 0, 0, 0, 1);
    checks++; if (dvec !== mvec()) bad("rst_idle_ignores", dvec, mvec());
  endtask

  task automatic test_random();
    logic s, r;
    logic [1:0] v;
    tick(1, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      s = $urandom_range(0, 29) == 0;
      v = 2'($urandom);
      r = $urandom_range(0, 3) != 0;
      tick(s, v, 9'($urandom), 9'($urandom), r);
      checks++; if (dvec !== mvec()) bad($sformatf("random_cycle%0d", i), dvec, mvec());
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skewed();
    test_backpressure();
    test_overflow();
    test_midframe_start();
    test_rstn_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/systolic_output_collector.md
# systolic_output_collector

Downstream stage of the 2x2 systolic array. Captures the bottom-row processing-element partial sums, which arrive skewed by one cycle per column, and re-aligns them into whole result rows. Each row is presented on a registered valid/ready output port. After SIZE rows of one matrix product have been handed off, the block flags completion and waits for the next `start`.

## Interface
- `ACC_WIDTH`, 9, width of one accumulated partial sum.
- `SIZE`, 2, array dimension: number of columns and rows per result matrix.
- `IDXW`, `SIZE>1 ? $clog2(SIZE) : 1`, row-index width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: flush, clear counters and flags, enter COLLECT.
- `col_valid`  in  SIZE  bit j qualifies column j's sum this cycle (PE `out_valid`).
- `col_sum`  in  SIZE*ACC_WIDTH  column j at `[j*ACC_WIDTH +: ACC_WIDTH]` (PE `part_sum_out`).
- `res_valid`  out  1  result row available.
- `res_ready`  in  1  consumer accepts the row when both valid and ready are high.
- `res_row`  out  SIZE*ACC_WIDTH  aligned row, same packing as `col_sum`.
- `res_row_idx`  out  IDXW  row number within the matrix, 0..SIZE-1.
- `res_last`  out  1  high with the row whose index is SIZE-1.
- `done`  out  1  all SIZE rows handed off; held until `start` or reset.
- `overflow`  out  1  sticky: a column sample was dropped.

## Operation
- Each column has a FIFO, SIZE entries deep, with its own count.
- FSM states:
  - IDLE (reset state): `col_valid` ignored.
  - COLLECT: `col_valid[j]` pushes `col_sum[j]` into FIFO j.
  - DONE: `done`=1; `col_valid` ignored.
- `start` in any state:
  - empties all FIFOs, clears the output register (`res_valid`=0), `rows_loaded`, `rows_sent` and `overflow`;
  - next state is COLLECT;
  - a `col_valid` in the same cycle is discarded.
- Load condition: state is COLLECT, every FIFO is non-empty, `rows_loaded` < SIZE, and (`res_valid`=0 or `res_ready`=1).
  - On load, one entry is popped from every FIFO and captured into `res_row`.
  - `res_row_idx` is set to `rows_loaded`; `res_last` is set to (`rows_loaded`==SIZE-1); `rows_loaded` increments.
- Handshake:
  - `res_valid && res_ready` increments `rows_sent`.
  - If no load happens in that cycle, `res_valid` drops to 0.
  - The handshake with `res_last`=1 moves the FSM to DONE on the next edge.
- Push when FIFO j is full: the push is accepted only if a pop happens on FIFO j in the same cycle. Otherwise the sample is dropped and `overflow` is set.
- FIFO contents left after SIZE rows have been loaded stay in place and are discarded by the next `start`.
- Sums are carried through unmodified: no arithmetic, no truncation.

## Timing
- Reset values: `res_valid`=0, `res_row`=0, `res_row_idx`=0, `res_last`=0, `done`=0, `overflow`=0, FSM=IDLE, all FIFOs empty.
- Latency: if the last column of a row is pushed at edge t, `res_valid` is high after edge t+1, provided the output register is free.
- Throughput: one row per cycle with `res_ready` held at 1.
- While `res_valid`=1 and `res_ready`=0, `res_row`, `res_row_idx` and `res_last` hold stable.
- `done` rises on the edge after the final handshake.
- A push and a pop on the same FIFO in the same cycle leave its count unchanged.
- `rstn` asserted mid-operation clears everything immediately (asynchronous); the block resumes in IDLE.

## Test plan
- Aligned input, SIZE=2, `res_ready`=1:
  - stimulus: `start`; then col0=5 and col1=7 both valid; next cycle col0=11 and col1=13.
  - required: row {col1=7,col0=5} with idx0; then row {13,11} with idx1 and `res_last`=1; `done`=1 one cycle after that.
- Skewed input: col0=5 at cycle t, col1=7 at t+1 -> `res_valid` first high at t+2, `res_row`={7,5}.
- Backpressure: hold `res_ready`=0 for 4 cycles with row0 pending -> outputs stay constant; row1 loads the cycle after `res_ready` rises.
- Overflow: col0 valid 3 consecutive cycles (1,2,3) while col1 stays idle -> value 3 is dropped and `overflow`=1. Then col1=9,10 -> rows {9,1} and {10,2}.
- Mid-frame `start` after one row sent, with col0 holding 4 -> FIFOs empty, `res_valid`=0, `overflow`=0, next row idx=0.
- `rstn` pulsed low mid-COLLECT -> all outputs 0 at once; `col_valid` ignored until `start`.
